div_iter: RTL and testbench

- Iterative radix-2 restoring divider for the execute stage. It is the inverse-operation companion of the Booth/Wallace multiplier.
- Serves DIV.W/DIV.WU/MOD.W/MOD.WU. One request is accepted at a time.
- Quotient and remainder are both produced; the pipeline selects which one to use.
- Request/response use valid/ready handshakes so the EXE stage can stall on a busy divider.

---
 rtl/div_iter.sv | 137 +++++++++++++
 tb/tb_div_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider producing quotient and remainder for DIV/MOD (signed and unsigned).
// Fixed latency of WIDTH+2 edges from acceptance to out_valid; cancel and async reset abort any operation.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_sx;
  logic             r_sy;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_ydiv;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_qbit;
  logic             w_last;
  logic             w_accept;

  function automatic logic [WIDTH-1:0] f_cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // One restoring step: shift in the next dividend bit, trial-subtract |y|
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial  = w_shift - {2'b00, r_ydiv};
  assign w_qbit   = ~w_trial[WIDTH+1];
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = div_valid && div_ready && !cancel;

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cancel) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (div_valid) w_state_nxt = S_PREP;
        S_PREP:  w_state_nxt = S_ITER;
        S_ITER:  if (w_last) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_DONE;
        S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    div_ready = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      r_x    <= '0;
      r_y    <= '0;
      r_sx   <= 1'b0;
      r_sy   <= 1'b0;
      r_dvd  <= '0;
      r_ydiv <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_s    <= '0;
      r_r    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x  <= x;
            r_y  <= y;
            r_sx <= div_signed & x[WIDTH-1];
            r_sy <= div_signed & y[WIDTH-1];
          end
        end
        S_PREP: begin
          r_dvd  <= f_cond_neg(r_x, r_sx);
          r_ydiv <= f_cond_neg(r_y, r_sy);
          r_rem  <= '0;
          r_cnt  <= '0;
        end
        S_ITER: begin
          r_rem <= w_qbit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          // Results stay untouched on cancel so s/r only change at a completed FIX
          if (!cancel) begin
            if (r_ydiv == '0) begin
              r_s <= '1;
              r_r <= r_x;
            end else begin
              r_s <= f_cond_neg(r_dvd, r_sx ^ r_sy);
              r_r <= f_cond_neg(r_rem[WIDTH-1:0], r_sx);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s = r_s;
  assign r = r_r;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: scoreboard of model results, latency, backpressure, cancel and async reset.
module tb_div_iter;

  localparam int W = 32;

  logic         div_clk = 1'b0;
  logic         resetn;
  logic         div_valid;
  logic         div_ready;
  logic         div_signed;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cancel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic [W-1:0] r;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] last_s = '0;
  logic [W-1:0] last_r = '0;

  div_iter #(.WIDTH(W)) dut (
    .div_clk   (div_clk),
    .resetn    (resetn),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_signed(div_signed),
    .x         (x),
    .y         (y),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .r         (r)
  );

  always #5 div_clk = ~div_clk;

  initial begin
    #400000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sbv;
    sa  = a;
    sbv = b;
    if (b == '0) begin
      e.s = '1;
      e.r = a;
    end else if (!sg) begin
      e.s = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.s = 32'h8000_0000;
      e.r = '0;
    end else begin
      e.s = sa / sbv;
      e.r = sa % sbv;
    end
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg, input int bp);
    exp_t e;
    int   n;
    sb.push_back(model(a, b, sg));
    chk("ready_before", 32'(div_ready), 32'd1);
    out_ready  = (bp == 0);
    x          = a;
    y          = b;
    div_signed = sg;
    div_valid  = 1'b1;
    tick();
    div_valid  = 1'b0;
    x          = $urandom;
    y          = $urandom;
    div_signed = ~sg;
    chk("ready_busy", 32'(div_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd34);
    e = sb.pop_front();
    if (out_valid) begin
      chk("quotient", s, e.s);
      chk("remainder", r, e.r);
      last_s = e.s;
      last_r = e.r;
      for (int i = 0; i < bp; i++) begin
        tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_ready", 32'(div_ready), 32'd0);
        chk("bp_s", s, e.s);
        chk("bp_r", r, e.r);
      end
      out_ready = 1'b1;
      tick();
      chk("ready_after", 32'(div_ready), 32'd1);
      chk("valid_after", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    x          = '0;
    y          = '0;
    cancel     = 1'b0;
    out_ready  = 1'b1;
    #12;
    chk("rst_ready", 32'(div_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_s", s, '0);
    chk("rst_r", r, '0);
    resetn = 1'b1;
    tick();

    run_op(32'd100, 32'd7, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'd5, 32'd0, 1'b1, 0);
    run_op(32'd5, 32'd0, 1'b0, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op(32'd12345, 32'd99, 1'b1, 5);

    // cancel wins over a simultaneous request in IDLE
    x = 32'd9; y = 32'd3; div_signed = 1'b0;
    div_valid = 1'b1; cancel = 1'b1;
    tick();
    div_valid = 1'b0; cancel = 1'b0;
    chk("cancel_idle_ready", 32'(div_ready), 32'd1);

    // cancel in ITER with counter at 10
    x = 32'd1000; y = 32'd3; div_signed = 1'b0; div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    repeat (11) tick();
    chk("pre_cancel_ready", 32'(div_ready), 32'd0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_ready", 32'(div_ready), 32'd1);
    chk("cancel_valid", 32'(out_valid), 32'd0);
    chk("cancel_s_held", s, last_s);
    chk("cancel_r_held", r, last_r);
    run_op(32'd100, 32'd7, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 5000);
      if (i % 3 == 1) rb = -rb;
      run_op(ra, rb, i[0], 0);
    end

    // asynchronous reset mid-ITER
    x = 32'd77; y = 32'd5; div_signed = 1'b0; div_valid = 1'b1;
    tick();
    div_valid = 1'b0;
    repeat (10) tick();
    chk("pre_rst_s", s, last_s);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(div_ready), 32'd1);
    chk("arst_s", s, '0);
    chk("arst_r", r, '0);
    #2;
    resetn = 1'b1;
    tick();
    chk("post_rst_ready", 32'(div_ready), 32'd1);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
